syst_apb_master: RTL and testbench
==================================

Name: syst_apb_master

Overview:
- APB requester that drives the systolic-array APB slave (syst_APB) from a simple valid/ready command port.
- Converts one command into one APB transfer (SETUP then ACCESS) and returns read data or a timeout error on a response port.
- Sits directly upstream of syst_APB; its p_* outputs connect one-to-one to the slave's p_* inputs.

Parameters:
- ADDR_W, 32, APB address width.
- DATA_W, 32, APB data width.
- TIMEOUT, 16, maximum ACCESS cycles without p_ready_i before abort; legal range 1..255.

Ports:
- p_clk_i  in  1  clock, rising edge.
- p_rst_i  in  1  reset, asynchronous, active-low.
- cmd_valid_i  in  1  command present.
- cmd_ready_o  out  1  command accepted this cycle when both are high.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDR_W  target address.
- cmd_dat_i  in  DATA_W  write data.
- rsp_valid_o  out  1  response present.
- rsp_ready_i  in  1  consumer takes the response.
- rsp_dat_o  out  DATA_W  read data; 0 for writes and on timeout.
- rsp_err_o  out  1  timeout occurred.
- p_sel_o  out  1  APB select.
- p_enable_o  out  1  APB enable.
- p_we_o  out  1  APB write.
- p_adr_o  out  ADDR_W  APB address.
- p_dat_o  out  DATA_W  APB write data.
- p_dat_i  in  DATA_W  APB read data.
- p_ready_i  in  1  APB ready.

Behaviour:
- Reset (asserted at any time, including mid-transfer): state returns to IDLE immediately.
  - All outputs go to 0 with no clock edge required.
  - Timeout counter cleared; any in-flight transfer is dropped with no response.
- FSM states:
  - IDLE: cmd_ready_o=1.
    - On cmd_valid_i, capture we/adr/dat into registers and go to SETUP.
    - Otherwise stay.
  - SETUP: p_sel_o=1, p_enable_o=0; p_adr_o, p_we_o and p_dat_o come from the captured registers.
    - p_ready_i is ignored here.
    - Unconditionally go to ACCESS.
  - ACCESS: p_sel_o=1, p_enable_o=1, address/control/data held stable.
    - If p_ready_i=1: latch rsp_dat_o = (read ? p_dat_i : 0), set rsp_err_o=0, go to RESP.
    - Else if the counter equals TIMEOUT-1: set rsp_dat_o=0, rsp_err_o=1, go to RESP.
    - Else increment the counter.
  - RESP: p_sel_o=0, p_enable_o=0, rsp_valid_o=1.
    - rsp_dat_o and rsp_err_o are held stable.
    - On rsp_ready_i go to IDLE, clear rsp_valid_o, and clear the counter.
- cmd_ready_o is 1 only in IDLE; cmd_valid_i in any other state is not accepted and must be held by the source.
- Latency for a zero-wait slave:
  - Command accepted at edge N.
  - SETUP during cycle N..N+1.
  - ACCESS during cycle N+1..N+2, completing at edge N+2.
  - rsp_valid_o high from N+2.
  - Command-to-command minimum is 4 cycles when rsp_ready_i is tied high.
- Timeout takes exactly TIMEOUT ACCESS cycles; p_ready_i arriving in the same cycle as the last count wins (response is success, not error).
- Outside SETUP/ACCESS: p_adr_o, p_we_o and p_dat_o hold their last values; p_sel_o and p_enable_o are 0.
- Counter width is 8 bits; no wrap is possible because TIMEOUT ≤ 255.

Decomposition:
- Package syst_apb_pkg holds:
  - typedef enum logic [1:0] apb_mst_state_t {IDLE, SETUP, ACCESS, RESP};
  - localparams SYST_ADDR_DATA_IN=32'd0 and SYST_ADDR_DATA_OUT=32'd4;
  - localparam APB_TIMEOUT_DEFAULT=16.
- No sub-module: the FSM, capture registers and counter live in one module.

Test Plan:
- Write, zero-wait slave: cmd (we=1, adr=0, dat=0xDEADBEEF) -> p_sel_o=1/p_enable_o=0 for one cycle, then p_enable_o=1 with p_dat_o=0xDEADBEEF and p_adr_o=0 -> rsp_valid_o=1, rsp_err_o=0, rsp_dat_o=0.
- Read, 3 wait states: cmd (we=0, adr=4); slave raises p_ready_i on the 4th ACCESS cycle with p_dat_i=0x12345678 -> ACCESS lasts 4 cycles with signals stable -> rsp_dat_o=0x12345678, rsp_err_o=0.
- Timeout: read adr=4 with p_ready_i held 0 -> exactly 16 ACCESS cycles -> rsp_err_o=1, rsp_dat_o=0, p_sel_o=0. Ready on the 16th ACCESS cycle -> rsp_err_o=0.
- Back-pressure: rsp_ready_i=0 for 5 cycles plus a new cmd_valid_i -> cmd_ready_o=0 and the response held. rsp_ready_i=1 -> IDLE, and the new command is accepted the next cycle.
- Reset mid-ACCESS: drop p_rst_i to 0 during a wait state -> p_sel_o, p_enable_o and rsp_valid_o are 0 immediately. After release, a 7-write burst to adr 0 with random data completes in order with no error.

Source files
------------

// File: rtl/syst_apb_pkg.sv
// Shared types and constants for the systolic-array APB requester.
// Register map of the syst_APB slave plus the master FSM encoding.
package syst_apb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } apb_mst_state_t;

  localparam logic [31:0] SYST_ADDR_DATA_IN  = 32'd0;
  localparam logic [31:0] SYST_ADDR_DATA_OUT = 32'd4;

  localparam int APB_TIMEOUT_DEFAULT = 16;

endpackage

// File: rtl/syst_apb_master.sv
// APB requester: one valid/ready command becomes one SETUP+ACCESS transfer.
// Returns read data or a timeout error on a valid/ready response port.
module syst_apb_master
  import syst_apb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = APB_TIMEOUT_DEFAULT
) (
  input  logic              p_clk_i,
  input  logic              p_rst_i,

  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ADDR_W-1:0] cmd_adr_i,
  input  logic [DATA_W-1:0] cmd_dat_i,

  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_dat_o,
  output logic              rsp_err_o,

  output logic              p_sel_o,
  output logic              p_enable_o,
  output logic              p_we_o,
  output logic [ADDR_W-1:0] p_adr_o,
  output logic [DATA_W-1:0] p_dat_o,
  input  logic [DATA_W-1:0] p_dat_i,
  input  logic              p_ready_i
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  apb_mst_state_t    state_q;
  apb_mst_state_t    state_d;

  logic [7:0]        cnt_q;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] dat_q;
  logic [DATA_W-1:0] rsp_dat_q;
  logic              rsp_err_q;

  logic              capture;
  logic              cnt_last;
  logic              acc_ok;
  logic              acc_tmo;
  logic              rsp_take;

  assign cnt_last = (cnt_q == CNT_LAST);

  always_ff @(posedge p_clk_i or negedge p_rst_i) begin
    if (!p_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (cmd_valid_i) state_d = SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (p_ready_i || cnt_last) state_d = RESP;
      RESP:    if (rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // cmd_ready is gated by reset so every output reads 0 while held in reset
  always_comb begin
    cmd_ready_o = 1'b0;
    p_sel_o     = 1'b0;
    p_enable_o  = 1'b0;
    rsp_valid_o = 1'b0;
    capture     = 1'b0;
    acc_ok      = 1'b0;
    acc_tmo     = 1'b0;
    rsp_take    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_o = p_rst_i;
        capture     = cmd_valid_i;
      end
      SETUP: begin
        p_sel_o = 1'b1;
      end
      ACCESS: begin
        p_sel_o    = 1'b1;
        p_enable_o = 1'b1;
        acc_ok     = p_ready_i;
        acc_tmo    = !p_ready_i && cnt_last;
      end
      RESP: begin
        rsp_valid_o = 1'b1;
        rsp_take    = rsp_ready_i;
      end
      default: begin
        cmd_ready_o = 1'b0;
      end
    endcase
  end

  always_ff @(posedge p_clk_i or negedge p_rst_i) begin
    if (!p_rst_i) begin
      we_q  <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
    end else if (capture) begin
      we_q  <= cmd_we_i;
      adr_q <= cmd_adr_i;
      dat_q <= cmd_dat_i;
    end
  end

  // ready wins over the final count, so a late slave still succeeds
  always_ff @(posedge p_clk_i or negedge p_rst_i) begin
    if (!p_rst_i) begin
      cnt_q <= '0;
    end else if (rsp_take) begin
      cnt_q <= '0;
    end else if (p_enable_o && !acc_ok && !acc_tmo) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  always_ff @(posedge p_clk_i or negedge p_rst_i) begin
    if (!p_rst_i) begin
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b0;
    end else if (acc_ok) begin
      rsp_dat_q <= we_q ? '0 : p_dat_i;
      rsp_err_q <= 1'b0;
    end else if (acc_tmo) begin
      rsp_dat_q <= '0;
      rsp_err_q <= 1'b1;
    end
  end

  assign p_we_o    = we_q;
  assign p_adr_o   = adr_q;
  assign p_dat_o   = dat_q;
  assign rsp_dat_o = rsp_dat_q;
  assign rsp_err_o = rsp_err_q;

endmodule

// File: tb/tb_syst_apb_master.sv
// Directed bench for syst_apb_master with hand-computed expectations.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_syst_apb_master;

  logic        clk;
  logic        rst_n;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_adr;
  logic [31:0] cmd_dat;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_dat;
  logic        rsp_err;
  logic        p_sel;
  logic        p_enable;
  logic        p_we;
  logic [31:0] p_adr;
  logic [31:0] p_dat_o;
  logic [31:0] p_dat_i;
  logic        p_ready;

  int n_chk;
  int n_pass;

  syst_apb_master #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(16)
  ) u_dut (
    .p_clk_i    (clk),
    .p_rst_i    (rst_n),
    .cmd_valid_i(cmd_valid),
    .cmd_ready_o(cmd_ready),
    .cmd_we_i   (cmd_we),
    .cmd_adr_i  (cmd_adr),
    .cmd_dat_i  (cmd_dat),
    .rsp_valid_o(rsp_valid),
    .rsp_ready_i(rsp_ready),
    .rsp_dat_o  (rsp_dat),
    .rsp_err_o  (rsp_err),
    .p_sel_o    (p_sel),
    .p_enable_o (p_enable),
    .p_we_o     (p_we),
    .p_adr_o    (p_adr),
    .p_dat_o    (p_dat_o),
    .p_dat_i    (p_dat_i),
    .p_ready_i  (p_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // present a command in IDLE; returns one step later in SETUP
  task automatic issue(input logic we,
                       input logic [31:0] adr,
                       input logic [31:0] dat);
    cmd_valid = 1'b1;
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic release_rsp();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  logic [31:0] burst [7];
  int          acc_cnt;

  initial begin
    n_chk     = 0;
    n_pass    = 0;
    rst_n     = 1'b0;
    cmd_valid = 1'b0;
    cmd_we    = 1'b0;
    cmd_adr   = '0;
    cmd_dat   = '0;
    rsp_ready = 1'b0;
    p_dat_i   = '0;
    p_ready   = 1'b0;

    tick();
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_sel",       32'(p_sel),     32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_adr",       p_adr,          32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_cmd_ready", 32'(cmd_ready), 32'd1);

    // write to a zero-wait slave
    p_ready = 1'b1;
    issue(1'b1, 32'd0, 32'hDEADBEEF);
    chk("wr_setup_sel", 32'(p_sel),     32'd1);
    chk("wr_setup_en",  32'(p_enable),  32'd0);
    chk("wr_setup_rdy", 32'(cmd_ready), 32'd0);
    tick();
    chk("wr_acc_en",  32'(p_enable), 32'd1);
    chk("wr_acc_dat", p_dat_o,       32'hDEADBEEF);
    chk("wr_acc_adr", p_adr,         32'd0);
    chk("wr_acc_we",  32'(p_we),     32'd1);
    tick();
    chk("wr_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("wr_rsp_err",   32'(rsp_err),   32'd0);
    chk("wr_rsp_dat",   rsp_dat,        32'd0);
    chk("wr_rsp_sel",   32'(p_sel),     32'd0);
    release_rsp();
    chk("wr_back_idle", 32'(cmd_ready), 32'd1);

    // read with three wait states
    p_ready = 1'b0;
    issue(1'b0, 32'd4, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("rd_acc_en",  32'(p_enable), 32'd1);
      chk("rd_acc_adr", p_adr,         32'd4);
      chk("rd_acc_we",  32'(p_we),     32'd0);
      if (i == 4) begin
        p_ready = 1'b1;
        p_dat_i = 32'h12345678;
      end
    end
    tick();
    p_ready = 1'b0;
    p_dat_i = '0;
    chk("rd_rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rd_rsp_dat",   rsp_dat,        32'h12345678);
    chk("rd_rsp_err",   32'(rsp_err),   32'd0);
    release_rsp();

    // timeout with the slave never ready
    p_dat_i = 32'hFFFFFFFF;
    issue(1'b0, 32'd4, 32'd0);
    acc_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (rsp_valid) break;
      if (p_enable) acc_cnt++;
    end
    chk("tmo_cycles", 32'(acc_cnt),   32'd16);
    chk("tmo_valid",  32'(rsp_valid), 32'd1);
    chk("tmo_err",    32'(rsp_err),   32'd1);
    chk("tmo_dat",    rsp_dat,        32'd0);
    chk("tmo_sel",    32'(p_sel),     32'd0);
    release_rsp();

    // ready arrives on the last counted cycle and wins
    issue(1'b0, 32'd4, 32'd0);
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 16) begin
        chk("edge_acc_en", 32'(p_enable), 32'd1);
        p_ready = 1'b1;
        p_dat_i = 32'hA5A5A5A5;
      end
    end
    tick();
    p_ready = 1'b0;
    chk("edge_valid", 32'(rsp_valid), 32'd1);
    chk("edge_err",   32'(rsp_err),   32'd0);
    chk("edge_dat",   rsp_dat,        32'hA5A5A5A5);

    // back-pressure while a new command waits
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_adr   = 32'd0;
    cmd_dat   = 32'h00000011;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      chk("bp_valid",     32'(rsp_valid), 32'd1);
      chk("bp_dat",       rsp_dat,        32'hA5A5A5A5);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("bp_idle_rdy", 32'(cmd_ready), 32'd1);
    chk("bp_idle_val", 32'(rsp_valid), 32'd0);
    tick();
    cmd_valid = 1'b0;
    chk("bp_new_sel", 32'(p_sel),   32'd1);
    chk("bp_new_dat", p_dat_o,      32'h00000011);
    p_ready = 1'b1;
    tick();
    tick();
    p_ready = 1'b0;
    chk("bp_new_rsp", 32'(rsp_valid), 32'd1);
    release_rsp();

    // reset in the middle of an ACCESS wait state
    issue(1'b0, 32'd4, 32'd0);
    tick();
    tick();
    chk("mid_acc_en", 32'(p_enable), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_sel",   32'(p_sel),     32'd0);
    chk("mrst_en",    32'(p_enable),  32'd0);
    chk("mrst_valid", 32'(rsp_valid), 32'd0);
    chk("mrst_rdy",   32'(cmd_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_rdy", 32'(cmd_ready), 32'd1);

    // write burst after reset, zero-wait slave
    for (int k = 0; k < 7; k++) burst[k] = $urandom;
    p_ready = 1'b1;
    for (int k = 0; k < 7; k++) begin
      issue(1'b1, 32'd0, burst[k]);
      tick();
      chk("burst_dat", p_dat_o, burst[k]);
      tick();
      chk("burst_valid", 32'(rsp_valid), 32'd1);
      chk("burst_err",   32'(rsp_err),   32'd0);
      release_rsp();
    end
    p_ready = 1'b0;

    // back-to-back commands with rsp_ready tied high take 4 cycles
    p_ready   = 1'b1;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    acc_cnt   = 0;
    tick();
    for (int i = 0; i < 20; i++) begin
      acc_cnt++;
      if (cmd_ready) break;
      tick();
    end
    chk("c2c_cycles", 32'(acc_cnt), 32'd4);
    cmd_valid = 1'b0;
    tick();
    p_ready   = 1'b0;
    rsp_ready = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
